stream_minmax: RTL and testbench

Streaming reduction stage that sits directly downstream of the signed less-than comparator. It accepts a frame of N-bit two's-complement samples over a valid/ready handshake and tracks the running minimum and maximum, plus the index of each, using two `comparator_lt` instances. When the frame ends it presents one result over a second valid/ready handshake. Its consumers are the datapath's sorting and bounds-checking logic.

---
 rtl/stream_minmax.sv | 141 ++++++++++++++
 tb/tb_stream_minmax.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_minmax.sv
// stream_minmax: streaming signed min/max reduction with first-occurrence
// indices, saturating sample count and a registered result handshake.

// Signed less-than comparator: o_lt = (i_a < i_b), two's complement.
module comparator_lt #(
   parameter int N = 32
) (
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   output logic         o_lt
);
   assign o_lt = $signed(i_a) < $signed(i_b);
endmodule

module stream_minmax #(
   parameter int N     = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     in_data,
   input  logic             in_valid,
   input  logic             in_last,
   output logic             in_ready,
   output logic [N-1:0]     min_out,
   output logic [N-1:0]     max_out,
   output logic [CNT_W-1:0] min_idx,
   output logic [CNT_W-1:0] max_idx,
   output logic [CNT_W-1:0] count,
   output logic             sat,
   output logic             out_valid,
   input  logic             out_ready
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCUM,
      S_DONE
   } state_t;

   state_t           r_state;
   logic [N-1:0]     r_min;
   logic [N-1:0]     r_max;
   logic [CNT_W-1:0] r_min_idx;
   logic [CNT_W-1:0] r_max_idx;
   logic [CNT_W-1:0] r_count;
   logic             r_sat;
   logic             r_out_valid;

   logic w_acc;
   logic w_lt_min;
   logic w_gt_max;
   logic w_cnt_full;

   // sample < current minimum
   comparator_lt #(.N(N)) u_lt_min (
      .i_a  (in_data),
      .i_b  (r_min),
      .o_lt (w_lt_min)
   );

   // current maximum < sample
   comparator_lt #(.N(N)) u_lt_max (
      .i_a  (r_max),
      .i_b  (in_data),
      .o_lt (w_gt_max)
   );

   assign in_ready   = ~rst & (r_state != S_DONE);
   assign w_acc      = in_valid & in_ready;
   assign w_cnt_full = &r_count;

   assign min_out   = r_min;
   assign max_out   = r_max;
   assign min_idx   = r_min_idx;
   assign max_idx   = r_max_idx;
   assign count     = r_count;
   assign sat       = r_sat;
   assign out_valid = r_out_valid;

   // Frame FSM: open on first sample, fold in samples, hold result until taken
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_min       <= '0;
         r_max       <= '0;
         r_min_idx   <= '0;
         r_max_idx   <= '0;
         r_count     <= '0;
         r_sat       <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_acc) begin
                  r_min       <= in_data;
                  r_max       <= in_data;
                  r_min_idx   <= '0;
                  r_max_idx   <= '0;
                  r_count     <= CNT_W'(1);
                  r_sat       <= 1'b0;
                  r_out_valid <= in_last;
                  r_state     <= in_last ? S_DONE : S_ACCUM;
               end
            end
            S_ACCUM: begin
               if (w_acc) begin
                  if (w_lt_min) begin
                     r_min     <= in_data;
                     r_min_idx <= r_count;
                  end
                  if (w_gt_max) begin
                     r_max     <= in_data;
                     r_max_idx <= r_count;
                  end
                  if (w_cnt_full) begin
                     r_sat <= 1'b1;
                  end else begin
                     r_count <= r_count + CNT_W'(1);
                  end
                  if (in_last) begin
                     r_out_valid <= 1'b1;
                     r_state     <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stream_minmax.sv
// tb_stream_minmax: randomized scoreboard bench for stream_minmax
// (CNT_W=16 and CNT_W=3 instances sharing one driver).

module tb_stream_minmax;

   typedef logic [31:0] sq_t[$];
   typedef struct packed {
      logic [31:0] mn;
      logic [31:0] mx;
      logic [15:0] mni;
      logic [15:0] mxi;
      logic [15:0] cnt;
      logic        st;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [31:0] in_data  = '0;
   logic        in_valid = 1'b0;
   logic        in_last  = 1'b0;
   logic        sel      = 1'b0;
   logic        out_ready = 1'b1;
   int          mode = 0;

   logic        a_rdy, a_sat, a_ov;
   logic [31:0] a_mn, a_mx;
   logic [15:0] a_mni, a_mxi, a_cnt;
   logic        b_rdy, b_sat, b_ov;
   logic [31:0] b_mn, b_mx;
   logic [2:0]  b_mni, b_mxi, b_cnt;

   stream_minmax #(.N(32), .CNT_W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid && !sel),
      .in_last   (in_last),
      .in_ready  (a_rdy),
      .min_out   (a_mn),
      .max_out   (a_mx),
      .min_idx   (a_mni),
      .max_idx   (a_mxi),
      .count     (a_cnt),
      .sat       (a_sat),
      .out_valid (a_ov),
      .out_ready (out_ready)
   );

   stream_minmax #(.N(32), .CNT_W(3)) dut3 (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid && sel),
      .in_last   (in_last),
      .in_ready  (b_rdy),
      .min_out   (b_mn),
      .max_out   (b_mx),
      .min_idx   (b_mni),
      .max_idx   (b_mxi),
      .count     (b_cnt),
      .sat       (b_sat),
      .out_valid (b_ov),
      .out_ready (out_ready)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [127:0] act,
                      input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: first occurrence of extreme, index clipped at 2^w-1.
   function automatic exp_t model(input sq_t s, input int w);
      exp_t e;
      int lim, n, ii;
      lim = (1 << w) - 1;
      n = s.size();
      e.mn = s[0];
      e.mx = s[0];
      e.mni = '0;
      e.mxi = '0;
      for (int i = 1; i < n; i++) begin
         ii = (i > lim) ? lim : i;
         if ($signed(s[i]) < $signed(e.mn)) begin
            e.mn = s[i];
            e.mni = 16'(ii);
         end
         if ($signed(s[i]) > $signed(e.mx)) begin
            e.mx = s[i];
            e.mxi = 16'(ii);
         end
      end
      e.cnt = 16'((n > lim) ? lim : n);
      e.st = (n > lim);
      return e;
   endfunction

   exp_t q0[$];
   exp_t q1[$];
   logic pv[2];
   logic phs[2];
   exp_t snap[2];

   task automatic mon(input int k, input logic ov, input exp_t a);
      exp_t e;
      int sz;
      if (pv[k] && !phs[k]) chk($sformatf("hold%0d", k), a, snap[k]);
      if (phs[k]) chk($sformatf("ov_fall%0d", k), ov, 0);
      if (ov && out_ready) begin
         sz = (k == 0) ? q0.size() : q1.size();
         if (sz == 0) begin
            chk($sformatf("unexpected_result%0d", k), 1, 0);
         end else begin
            e = (k == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("min%0d", k), a.mn, e.mn);
            chk($sformatf("max%0d", k), a.mx, e.mx);
            chk($sformatf("min_idx%0d", k), a.mni, e.mni);
            chk($sformatf("max_idx%0d", k), a.mxi, e.mxi);
            chk($sformatf("count%0d", k), a.cnt, e.cnt);
            chk($sformatf("sat%0d", k), a.st, e.st);
         end
      end
      pv[k] = ov;
      phs[k] = ov && out_ready;
      snap[k] = a;
   endtask

   always @(negedge clk) begin
      if (rst) begin
         pv[0] = 0; pv[1] = 0;
         phs[0] = 0; phs[1] = 0;
      end else begin
         mon(0, a_ov, {a_mn, a_mx, a_mni, a_mxi, a_cnt, a_sat});
         mon(1, b_ov, {b_mn, b_mx, {13'b0, b_mni}, {13'b0, b_mxi},
                       {13'b0, b_cnt}, b_sat});
      end
   end

   always @(posedge clk) begin
      #2;
      case (mode)
         0: out_ready = 1'b1;
         1: out_ready = 1'($urandom_range(0, 1));
         default: out_ready = 1'b0;
      endcase
   end

   task automatic send_frame(input sq_t s, input bit k, input int gap,
                             input bit full);
      int n, wc;
      n = s.size();
      sel = k;
      if (full) begin
         if (k == 0) q0.push_back(model(s, 16));
         else q1.push_back(model(s, 3));
      end
      for (int i = 0; i < n; i++) begin
         if ((gap == 1 && i > 0) || (gap == 2 && $urandom_range(0, 2) == 0)) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
         end
         in_valid = 1'b1;
         in_data = s[i];
         in_last = full && (i == n - 1);
         wc = 0;
         @(negedge clk);
         while (!(k ? b_rdy : a_rdy) && wc < 200) begin
            @(negedge clk);
            wc++;
         end
         if (wc >= 200) chk("in_ready_timeout", 0, 1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_last = 1'b0;
      if (full) chk("latency_ov", k ? b_ov : a_ov, 1);
   endtask

   task automatic drain();
      int wc;
      wc = 0;
      while ((q0.size() != 0 || q1.size() != 0 || a_ov || b_ov) && wc < 500) begin
         @(posedge clk); #1;
         wc++;
      end
      if (wc >= 500) chk("drain_timeout", 0, 1);
   endtask

   function automatic logic [31:0] rnd_val();
      case ($urandom_range(0, 4))
         0: return 32'h8000_0000;
         1: return 32'h7FFF_FFFF;
         2: return 32'($urandom_range(0, 3)) - 32'd1;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      sq_t s;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", a_rdy, 0);
      chk("rst_ov", a_ov, 0);
      chk("rst_outs", {a_mn, a_mx, a_mni, a_mxi, a_cnt, a_sat}, 0);
      rst = 1'b0;
      #1;
      chk("rdy_after_rst", a_rdy, 1);

      s = '{32'd5, -32'sd3, 32'd7, -32'sd3, 32'd7};
      send_frame(s, 0, 0, 1);
      chk("t1_min", a_mn, 32'hFFFF_FFFD);
      chk("t1_min_idx", a_mni, 1);
      chk("t1_max", a_mx, 7);
      chk("t1_max_idx", a_mxi, 2);
      chk("t1_count", a_cnt, 5);
      chk("t1_rdy_done", a_rdy, 0);
      drain();

      s = '{32'h8000_0000};
      send_frame(s, 0, 0, 1);
      drain();

      s = '{32'hFFFF_FFFF, 32'd0, 32'h7FFF_FFFF, 32'h8000_0000};
      send_frame(s, 0, 1, 1);
      drain();

      mode = 2;
      @(posedge clk); #3;
      s = '{32'd3, 32'd9, 32'd1};
      send_frame(s, 0, 0, 1);
      repeat (4) begin
         @(posedge clk); #1;
         chk("bp_in_ready", a_rdy, 0);
         chk("bp_ov", a_ov, 1);
      end
      mode = 0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_ov_after", a_ov, 0);
      chk("bp_rdy_after", a_rdy, 1);
      s = '{32'd4, 32'd4};
      send_frame(s, 0, 0, 1);
      drain();

      s = '{32'd10, 32'd20, 32'd5, 32'd30, 32'd8, 32'd9, 32'd11, 32'd12,
            -32'sd100};
      send_frame(s, 1, 0, 1);
      chk("c3_count", b_cnt, 7);
      chk("c3_sat", b_sat, 1);
      chk("c3_min_idx", b_mni, 7);
      chk("c3_max_idx", b_mxi, 3);
      drain();

      s = '{32'd9, 32'd8, 32'd7};
      send_frame(s, 0, 0, 0);
      chk("partial_count", a_cnt, 3);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_rdy", a_rdy, 0);
      chk("mid_rst_outs", {a_ov, a_mn, a_mx, a_mni, a_mxi, a_cnt, a_sat}, 0);
      rst = 1'b0;
      #1;
      chk("mid_rst_rdy_after", a_rdy, 1);
      s = '{32'd2, 32'd1};
      send_frame(s, 0, 0, 1);
      drain();

      mode = 1;
      for (int f = 0; f < 30; f++) begin
         s = {};
         for (int j = 0; j < int'($urandom_range(1, 12)); j++)
            s.push_back(rnd_val());
         send_frame(s, 1'(f % 3 == 2), 2, 1);
      end
      mode = 0;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
